// File: rtl/primitive_example_pkg.sv
// Shared definitions for the single-port RAM write path and its serializing read path.
package primitive_example_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/infer_single_port_ram.sv
// Single-port RAM with a registered read address; q follows the captured address.
module infer_single_port_ram
  import primitive_example_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    addr_q <= addr;
  end

  assign q = mem[addr_q];

endmodule

// File: rtl/ser_piso_reg.sv
// Parallel-load / shift-left register that tracks which bit of the word is on the line.
module ser_piso_reg
  import primitive_example_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          shift,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic                          msb,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_idx,
  output logic                          last_bit
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;

  always_comb begin
    shift_reg_d = shift_reg_q;
    bit_idx_d   = bit_idx_q;
    if (load) begin
      shift_reg_d = din;
      bit_idx_d   = '0;
    end else if (shift) begin
      shift_reg_d = {shift_reg_q[DATA_WIDTH-2:0], 1'b0};
      bit_idx_d   = bit_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg_q <= '0;
      bit_idx_q   <= '0;
    end else begin
      shift_reg_q <= shift_reg_d;
      bit_idx_q   <= bit_idx_d;
    end
  end

  assign msb      = shift_reg_q[DATA_WIDTH-1];
  assign bit_idx  = bit_idx_q;
  assign last_bit = (bit_idx_q == IDX_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/ram_stream_serializer.sv
// Scans a block of RAM words and streams them MSB-first, back-to-back, with address prefetch.
module ram_stream_serializer
  import primitive_example_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  ser_out,
  output logic                  ser_oe,
  output logic                  ser_first,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned REM_W = ADDR_WIDTH + 1;
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [REM_W-1:0]      remaining_q, remaining_d;
  logic                  fetch_wait_q, fetch_wait_d;
  logic                  zero_done_q, zero_done_d;

  logic                  piso_load, piso_shift;
  logic                  piso_msb, piso_last;
  logic [IDX_W-1:0]      piso_idx;

  ser_piso_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (piso_load),
    .shift    (piso_shift),
    .din      (ram_q),
    .msb      (piso_msb),
    .bit_idx  (piso_idx),
    .last_bit (piso_last)
  );

  // remaining counts words not yet fully sent, including the one in the shifter
  always_comb begin
    state_d      = state_q;
    ram_addr_d   = ram_addr_q;
    remaining_d  = remaining_q;
    fetch_wait_d = 1'b0;
    zero_done_d  = 1'b0;
    piso_load    = 1'b0;
    piso_shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            ram_addr_d   = start_addr;
            remaining_d  = word_count;
            fetch_wait_d = 1'b1;
            state_d      = FETCH;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!fetch_wait_q) begin
          piso_load = 1'b1;
          state_d   = SHIFT;
          if (remaining_q > REM_W'(1)) begin
            ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (piso_last) begin
          if (remaining_q > REM_W'(1)) begin
            piso_load   = 1'b1;
            remaining_d = remaining_q - REM_W'(1);
            if (remaining_q > REM_W'(2)) begin
              ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
            end
          end else begin
            state_d = FIN;
          end
        end else begin
          piso_shift = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ram_addr_q   <= '0;
      remaining_q  <= '0;
      fetch_wait_q <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      remaining_q  <= remaining_d;
      fetch_wait_q <= fetch_wait_d;
      zero_done_q  <= zero_done_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ser_oe    = (state_q == SHIFT);
  assign ser_out   = ser_oe & piso_msb;
  assign ser_first = ser_oe & (piso_idx == '0);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN) | zero_done_q;

endmodule

// File: tb/tb_ram_stream_serializer.sv
// Randomized and directed bench for ram_stream_serializer paired with the inferred RAM.
module tb_ram_stream_serializer;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [AW-1:0] start_addr;
  logic [AW:0]   word_count;
  logic [AW-1:0] dut_ram_addr;
  logic [DW-1:0] ram_q;
  logic          ser_out, ser_oe, ser_first, busy, done;

  logic          tb_load, ram_we;
  logic [AW-1:0] tb_addr, ram_addr_mux;
  logic [DW-1:0] ram_din;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_model [DEPTH];

  assign ram_addr_mux = tb_load ? tb_addr : dut_ram_addr;

  ram_stream_serializer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .abort      (abort),
    .ram_addr   (dut_ram_addr),
    .ram_q      (ram_q),
    .ser_out    (ser_out),
    .ser_oe     (ser_oe),
    .ser_first  (ser_first),
    .busy       (busy),
    .done       (done)
  );

  infer_single_port_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr_mux),
    .din  (ram_din),
    .q    (ram_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ram_write(input int unsigned a, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    tb_load = 1'b1;
    ram_we  = 1'b1;
    tb_addr = AW'(a);
    ram_din = d;
    @(posedge clk);
    #1;
    ram_we  = 1'b0;
    tb_load = 1'b0;
    mem_model[a] = d;
  endtask

  // abort_k / restart_k: sample index at which abort / a spurious start is driven (-1 = never)
  task automatic run_xfer(input int unsigned addr, input int unsigned cnt,
                          input int abort_k, input int restart_k, input bit chk_addr);
    bit            exp_bits[$];
    logic [AW-1:0] trail[$];
    logic [DW-1:0] word;
    int            nbits, nsamp;
    logic          e_oe, e_busy, e_done, e_first, e_out, aborted;

    for (int unsigned w = 0; w < cnt; w++) begin
      word = mem_model[(addr + w) % DEPTH];
      for (int b = DW - 1; b >= 0; b--) exp_bits.push_back(word[b]);
    end
    nbits = int'(cnt) * DW;
    nsamp = (cnt == 0) ? 3 : nbits + 4;
    if (abort_k >= 0) nsamp = abort_k + 4;

    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = AW'(addr);
    word_count = (AW+1)'(cnt);

    for (int k = 0; k < nsamp; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) start = 1'b0;
      if (restart_k > 0 && k == restart_k) begin
        start      = 1'b1;
        start_addr = '0;
        word_count = (AW+1)'(2);
      end else if (restart_k > 0 && k == restart_k + 1) begin
        start = 1'b0;
      end
      abort = (k == abort_k);
      @(negedge clk);

      aborted = (abort_k >= 0) && (k > abort_k);
      if (cnt == 0) begin
        e_oe = 1'b0; e_busy = 1'b0; e_done = (k == 0);
      end else if (aborted) begin
        e_oe = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end else begin
        e_oe   = (k >= 2) && (k < 2 + nbits);
        e_busy = (k < 3 + nbits);
        e_done = (k == 2 + nbits);
      end
      e_first = e_oe && (((k - 2) % DW) == 0);
      e_out   = e_oe ? exp_bits[k-2] : 1'b0;

      check("ser_oe",    32'(ser_oe),    32'(e_oe));
      check("busy",      32'(busy),      32'(e_busy));
      check("done",      32'(done),      32'(e_done));
      check("ser_first", 32'(ser_first), 32'(e_first));
      check("ser_out",   32'(ser_out),   32'(e_out));

      if (chk_addr && e_busy && (trail.size() == 0 || trail[$] != dut_ram_addr))
        trail.push_back(dut_ram_addr);
    end
    abort = 1'b0;

    if (chk_addr) begin
      check("addr_trail_len", 32'(trail.size()), 32'(cnt));
      for (int i = 0; i < trail.size() && i < int'(cnt); i++)
        check("addr_trail", 32'(trail[i]), 32'((addr + i) % DEPTH));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ser_out"},   32'(ser_out),      32'(0));
    check({tag, "_ser_oe"},    32'(ser_oe),       32'(0));
    check({tag, "_ser_first"}, 32'(ser_first),    32'(0));
    check({tag, "_busy"},      32'(busy),         32'(0));
    check({tag, "_done"},      32'(done),         32'(0));
    check({tag, "_ram_addr"},  32'(dut_ram_addr), 32'(0));
  endtask

  task automatic reset_mid_shift();
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = AW'(10);
    word_count = (AW+1)'(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_rst_oe", 32'(ser_oe), 32'(1));
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_busy", 32'(busy),   32'(0));
      check("post_rst_oe",   32'(ser_oe), 32'(0));
      check("post_rst_done", 32'(done),   32'(0));
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    start_addr = '0;
    word_count = '0;
    tb_load    = 1'b0;
    ram_we     = 1'b0;
    tb_addr    = '0;
    ram_din    = '0;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    for (int unsigned a = 0; a < DEPTH; a++) ram_write(a, DW'($urandom));
    ram_write(5,  8'hA5);
    ram_write(62, 8'hFF);
    ram_write(63, 8'h00);
    ram_write(0,  8'h81);

    run_xfer(5, 1, -1, -1, 1'b0);
    run_xfer(62, 3, -1, -1, 1'b1);
    run_xfer(17, 0, -1, -1, 1'b0);
    run_xfer(20, 4, -1, 10, 1'b1);
    run_xfer(30, 4, 13, -1, 1'b0);
    run_xfer(31, 2, -1, -1, 1'b1);
    reset_mid_shift();
    run_xfer(40, 1, 1, -1, 1'b0);
    run_xfer(40, 2, -1, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(0, 9), -1, -1, 1'b1);
    end
    run_xfer($urandom_range(0, DEPTH - 1), DEPTH, -1, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
